// File: rtl/mem_load_pkg.sv
// Shared types for the load-return path: stage states, captured request, width codes.
// Width encodings mirror memWidth1/memWidth2/memWidth4 from constants.v.
package mem_load_pkg;

  localparam logic [1:0] memWidth1 = 2'b00;
  localparam logic [1:0] memWidth2 = 2'b01;
  localparam logic [1:0] memWidth4 = 2'b10;

  // Widest destination index the captured request can carry.
  localparam int unsigned DST_W_MAX = 8;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HELD
  } state_e;

  typedef struct packed {
    logic [31:0]          addr;
    logic [1:0]           width;
    logic                 is_signed;
    logic [DST_W_MAX-1:0] dst;
  } load_req_t;

  function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] width);
    case (width)
      memWidth1: return 1'b0;
      memWidth2: return addr[0];
      default:   return addr[1:0] != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational lane select and sign/zero extension of a 32-bit SRAM read word.
module load_formatter
  import mem_load_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  width_i,
  input  logic        is_signed_i,
  output logic [31:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase

    // Unused width code 2'b11 falls through to the full word.
    case (width_i)
      memWidth1: data_o = {{24{is_signed_i & byte_sel[7]}}, byte_sel};
      memWidth2: data_o = {{16{is_signed_i & half[15]}}, half};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_align_stage.sv
// Load-return stage: captures the load request, formats SRAM read data one cycle later,
// and holds the result across stalls. Optional macro: LOAD_MISALIGN_EXC_EN.
module load_align_stage
  import mem_load_pkg::*;
#(
  parameter int unsigned DST_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_width,
  input  logic             req_signed,
  input  logic [DST_W-1:0] req_dst,
  output logic             req_misaligned,
  input  logic [31:0]      data_sram_rdata,
  output logic             ld_valid,
  output logic [31:0]      ld_data,
  output logic [DST_W-1:0] ld_dst,
  output logic             ld_exception,
  output logic [31:0]      ld_badvaddr
);

  state_e      state_q, state_d;
  load_req_t   req_q, req_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] fmt_data;
  logic [31:0] live_data;
  logic        accept;
  logic        exc_cur;
  logic        unused_req;

  assign accept = req_valid && !stall && !flush;

`ifdef LOAD_MISALIGN_EXC_EN
  assign req_misaligned = misaligned(req_addr, req_width);
  assign exc_cur        = misaligned(req_q.addr, req_q.width);
`else
  assign req_misaligned = 1'b0;
  assign exc_cur        = 1'b0;
`endif

  load_formatter u_formatter (
    .rdata_i     (data_sram_rdata),
    .addr_lo_i   (req_q.addr[1:0]),
    .width_i     (req_q.width),
    .is_signed_i (req_q.is_signed),
    .data_o      (fmt_data)
  );

  assign live_data = exc_cur ? '0 : fmt_data;

  // hold_q tracks every RESP result, so it serves both as stall buffer and as the
  // "last value" ld_data shows while idle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    hold_d  = hold_q;

    if (accept) begin
      req_d = '{addr: req_addr, width: req_width, is_signed: req_signed,
                dst: DST_W_MAX'(req_dst)};
    end
    if (state_q == RESP && !flush) begin
      hold_d = live_data;
    end

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       state_d = accept ? RESP : IDLE;
        RESP, HELD: state_d = stall ? HELD : (accept ? RESP : IDLE);
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
    end
  end

  assign ld_valid     = state_q != IDLE;
  assign ld_data      = (state_q == RESP) ? live_data : hold_q;
  assign ld_dst       = req_q.dst[DST_W-1:0];
  assign ld_exception = ld_valid && exc_cur;
  assign ld_badvaddr  = ld_exception ? req_q.addr : '0;

  assign unused_req = ^{req_q.addr, req_q.dst};

endmodule

// File: tb/tb_load_align_stage.sv
// Directed, table-driven bench for load_align_stage; honours LOAD_MISALIGN_EXC_EN.
module tb_load_align_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, req_valid, req_signed;
  logic [31:0] req_addr, data_sram_rdata;
  logic [1:0]  req_width;
  logic [4:0]  req_dst;
  logic        req_misaligned, ld_valid, ld_exception;
  logic [31:0] ld_data, ld_badvaddr;
  logic [4:0]  ld_dst;

  int pass_cnt  = 0;
  int total_cnt = 0;

  load_align_stage #(.DST_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_width       (req_width),
    .req_signed      (req_signed),
    .req_dst         (req_dst),
    .req_misaligned  (req_misaligned),
    .data_sram_rdata (data_sram_rdata),
    .ld_valid        (ld_valid),
    .ld_data         (ld_data),
    .ld_dst          (ld_dst),
    .ld_exception    (ld_exception),
    .ld_badvaddr     (ld_badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Move to 1 time unit after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [1:0] w, input logic s,
                           input logic [4:0] d);
    req_valid  = 1'b1;
    req_addr   = a;
    req_width  = w;
    req_signed = s;
    req_dst    = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat[4];
    pat[0] = 32'h0101_0101; pat[1] = 32'h0202_0202;
    pat[2] = 32'h0303_0303; pat[3] = 32'h0404_0404;

    vecs[0] = '{32'h0000_0003, 2'b00, 1'b1, 32'h80FF_FF11, 32'hFFFF_FF80};
    vecs[1] = '{32'h0000_0002, 2'b01, 1'b0, 32'hBEEF_1234, 32'h0000_BEEF};
    vecs[2] = '{32'h0000_0000, 2'b10, 1'b0, 32'hBEEF_1234, 32'hBEEF_1234};
    vecs[3] = '{32'h0000_0011, 2'b00, 1'b0, 32'h1234_56F7, 32'h0000_0056};
    vecs[4] = '{32'h0000_0022, 2'b00, 1'b1, 32'h12F4_5678, 32'hFFFF_FFF4};
    vecs[5] = '{32'h0000_0040, 2'b00, 1'b1, 32'h0000_007F, 32'h0000_007F};
    vecs[6] = '{32'h0000_0080, 2'b01, 1'b1, 32'h0000_8001, 32'hFFFF_8001};
    vecs[7] = '{32'h0000_0082, 2'b01, 1'b1, 32'h7FFF_0000, 32'h0000_7FFF};
    vecs[8] = '{32'h0000_0103, 2'b00, 1'b0, 32'hFF00_0000, 32'h0000_00FF};
    vecs[9] = '{32'h0000_0200, 2'b11, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};

    reset = 1'b0; stall = 1'b0; flush = 1'b0; req_valid = 1'b0;
    req_addr = '0; req_width = '0; req_signed = 1'b0; req_dst = '0;
    data_sram_rdata = 32'h5555_AAAA;
    step(); step();
    check("reset_valid", 32'(ld_valid), 32'd0);
    check("reset_data", ld_data, 32'd0);
    check("reset_dst", 32'(ld_dst), 32'd0);
    check("reset_exc", 32'(ld_exception), 32'd0);
    check("reset_badv", ld_badvaddr, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      drive_req(vecs[i].addr, vecs[i].width, vecs[i].sgn, 5'(i + 1));
      #1 check($sformatf("vec%0d_misal", i), 32'(req_misaligned), 32'd0);
      step();
      req_valid = 1'b0;
      data_sram_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d_valid", i), 32'(ld_valid), 32'd1);
      check($sformatf("vec%0d_data", i), ld_data, vecs[i].exp);
      check($sformatf("vec%0d_dst", i), 32'(ld_dst), 32'(i + 1));
    end
    step();
    check("idle_valid", 32'(ld_valid), 32'd0);
    check("idle_data_holds", ld_data, 32'hCAFE_F00D);

    // LW, stall for three cycles while rdata changes, then release.
    drive_req(32'h0000_0300, 2'b10, 1'b0, 5'd9);
    step();
    req_valid = 1'b0; stall = 1'b1; data_sram_rdata = 32'h1111_2222;
    #1 check("stall_n1_data", ld_data, 32'h1111_2222);
    step();
    data_sram_rdata = 32'hDEAD_0000;
    #1 check("stall_n2_valid", 32'(ld_valid), 32'd1);
    check("stall_n2_data", ld_data, 32'h1111_2222);
    step();
    check("stall_n3_valid", 32'(ld_valid), 32'd1);
    check("stall_n3_data", ld_data, 32'h1111_2222);
    step();
    stall = 1'b0;
    #1 check("stall_n4_valid", 32'(ld_valid), 32'd1);
    check("stall_n4_data", ld_data, 32'h1111_2222);
    check("stall_n4_dst", 32'(ld_dst), 32'd9);
    step();
    check("stall_n5_valid", 32'(ld_valid), 32'd0);

    // Back-to-back LW every cycle.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_req(32'(k * 4), 2'b10, 1'b0, 5'(k + 1));
      else req_valid = 1'b0;
      if (k > 0) begin
        data_sram_rdata = pat[k-1];
        #1;
        check($sformatf("b2b%0d_valid", k), 32'(ld_valid), 32'd1);
        check($sformatf("b2b%0d_data", k), ld_data, pat[k-1]);
        check($sformatf("b2b%0d_dst", k), 32'(ld_dst), 32'(k));
      end
      step();
    end
    check("b2b_end_valid", 32'(ld_valid), 32'd0);

    // Flush together with a request: nothing captured.
    drive_req(32'h0000_0400, 2'b10, 1'b0, 5'd3);
    flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    #1 check("flush_req_valid", 32'(ld_valid), 32'd0);

    // Request while stalled is ignored.
    drive_req(32'h0000_0404, 2'b10, 1'b0, 5'd4);
    stall = 1'b1;
    step();
    req_valid = 1'b0; stall = 1'b0;
    #1 check("stall_req_ignored", 32'(ld_valid), 32'd0);

    // Flush out of HELD, overriding stall.
    drive_req(32'h0000_0408, 2'b10, 1'b0, 5'd5);
    step();
    req_valid = 1'b0; stall = 1'b1;
    step();
    check("held_valid", 32'(ld_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1 check("flush_held_valid", 32'(ld_valid), 32'd0);

    // Reset while HELD.
    drive_req(32'h0000_040C, 2'b10, 1'b0, 5'd6);
    stall = 1'b0;
    step();
    req_valid = 1'b0; stall = 1'b1; data_sram_rdata = 32'h7777_8888;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1; stall = 1'b0;
    #1 check("rst_held_valid", 32'(ld_valid), 32'd0);
    check("rst_held_data", ld_data, 32'd0);
    check("rst_held_dst", 32'(ld_dst), 32'd0);

    // Misaligned LW.
    drive_req(32'h0000_1002, 2'b10, 1'b0, 5'd7);
    #1;
`ifdef LOAD_MISALIGN_EXC_EN
    check("misal_flag", 32'(req_misaligned), 32'd1);
`else
    check("misal_flag", 32'(req_misaligned), 32'd0);
`endif
    step();
    req_valid = 1'b0; data_sram_rdata = 32'hAABB_CCDD;
    #1 check("misal_valid", 32'(ld_valid), 32'd1);
`ifdef LOAD_MISALIGN_EXC_EN
    check("misal_exc", 32'(ld_exception), 32'd1);
    check("misal_badv", ld_badvaddr, 32'h0000_1002);
    check("misal_data", ld_data, 32'd0);
`else
    check("misal_exc", 32'(ld_exception), 32'd0);
    check("misal_badv", ld_badvaddr, 32'd0);
    check("misal_data", ld_data, 32'hAABB_CCDD);
`endif

    // Misaligned LH: low half when addr[0] is ignored.
    step();
    drive_req(32'h0000_1001, 2'b01, 1'b0, 5'd8);
    #1;
`ifdef LOAD_MISALIGN_EXC_EN
    check("misal_h_flag", 32'(req_misaligned), 32'd1);
`else
    check("misal_h_flag", 32'(req_misaligned), 32'd0);
`endif
    step();
    req_valid = 1'b0; data_sram_rdata = 32'h1234_9876;
    #1;
`ifdef LOAD_MISALIGN_EXC_EN
    check("misal_h_data", ld_data, 32'd0);
`else
    check("misal_h_data", ld_data, 32'h0000_9876);
`endif
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
